fsm: RTL and testbench

- Health-indicator controller for the board status lamp and the protection relay.
- Consumes an already-qualified fault flag (true_fault) and drives:
  - light: the status lamp.
  - relay_driver: a fail-safe relay coil, energised only while the system is healthy.
- Sits between the fault-qualification logic and the output pad drivers.
- Sequence: lamp test after reset, healthy, fault with blinking lamp, then timed hold before recovery.

---
 rtl/fsm_if.sv | 9 +
 rtl/fsm.sv | 138 +++++++++++++
 tb/tb_fsm.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fsm_if.sv
// Status-lamp / relay controller pin bundle: qualified fault in, lamp and relay drive out.
interface fsm_if;
  logic true_fault;
  logic light;
  logic relay_driver;

  modport master (output true_fault, input light, input relay_driver);
  modport slave  (input true_fault, output light, output relay_driver);
endinterface

// File: rtl/fsm.sv
// Health-indicator controller: lamp test, healthy, blinking fault, timed hold before recovery.
// Define FSM_LATCH_FAULT_EN to latch a fault until reset instead of recovering through HOLD.
//
// state     | meaning
// LAMP_TEST | lamp on, relay tripped, after reset release
// HEALTHY   | lamp on, relay energised
// FAULT     | lamp blinking, relay tripped
// HOLD      | lamp off, relay tripped, waiting for fault-free cycles
module fsm #(
  parameter int LAMP_TEST_CYCLES = 2,
  parameter int HOLD_CYCLES      = 4,
  parameter int BLINK_HALF       = 2
) (
  input  logic  clk,
  input  logic  reset,
  fsm_if.slave  io
);

  localparam int MAX_P = (LAMP_TEST_CYCLES > HOLD_CYCLES) ?
                         ((LAMP_TEST_CYCLES > BLINK_HALF) ? LAMP_TEST_CYCLES : BLINK_HALF) :
                         ((HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF);
  localparam int CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] LT_END    = CW'(LAMP_TEST_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BLINK_END = CW'(BLINK_HALF - 1);

  localparam logic [1:0] LAMP_TEST = 2'd0;
  localparam logic [1:0] HEALTHY   = 2'd1;
  localparam logic [1:0] FAULT     = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;

`ifdef FSM_LATCH_FAULT_EN
  localparam bit LATCH_FAULT = 1'b1;
`else
  localparam bit LATCH_FAULT = 1'b0;
`endif

  logic          flt_m, flt_s;
  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          blink, blink_nx;
  logic          light_dec, relay_dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_m <= 1'b0;
      flt_s <= 1'b0;
    end else begin
      flt_m <= io.true_fault;
      flt_s <= flt_m;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    blink_nx = blink;
    case (state)
      LAMP_TEST: begin
        if (cnt == LT_END) begin
          state_nx = flt_s ? FAULT : HEALTHY;
          cnt_nx   = '0;
          blink_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HEALTHY: begin
        if (flt_s) begin
          state_nx = FAULT;
          cnt_nx   = '0;
          blink_nx = 1'b0;
        end
      end
      FAULT: begin
        if (!flt_s && !LATCH_FAULT) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else if (cnt == BLINK_END) begin
          cnt_nx   = '0;
          blink_nx = ~blink;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HOLD: begin
        // a returning fault wins even on the expiry cycle
        if (flt_s) begin
          state_nx = FAULT;
          cnt_nx   = '0;
          blink_nx = 1'b0;
        end else if (cnt == HOLD_END) begin
          state_nx = HEALTHY;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = LAMP_TEST;
        cnt_nx   = '0;
        blink_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LAMP_TEST;
      cnt   <= '0;
      blink <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      blink <= blink_nx;
    end
  end

  always_comb begin
    light_dec = 1'b0;
    relay_dec = 1'b0;
    case (state)
      LAMP_TEST: light_dec = 1'b1;
      HEALTHY: begin
        light_dec = 1'b1;
        relay_dec = 1'b1;
      end
      FAULT:   light_dec = blink;
      default: light_dec = 1'b0;
    endcase
  end

  // both pads are forced dark/tripped for as long as reset is held
  assign io.light        = reset & light_dec;
  assign io.relay_driver = reset & relay_dec;

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for fsm: driver queues expected {light, relay_driver}, monitor pops and compares.
module tb_fsm;

  typedef struct {
    string      name;
    logic [1:0] val;
  } exp_t;

  logic clk;
  logic reset;
  fsm_if bus ();

  exp_t sb[$];
  event chk_ev;
  int   vectors = 0;
  int   fails   = 0;

  fsm dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      exp_t e;
      @(chk_ev);
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        e = sb.pop_front();
        vectors++;
        if ({bus.light, bus.relay_driver} !== e.val)
          begin
            fails++;
            $display("FAIL %s at %0t: light/relay got %b%b, want %b%b", e.name, $time,
                     bus.light, bus.relay_driver, e.val[1], e.val[0]);
          end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step(input string name, input logic r, input logic tf, input logic [1:0] ex);
    exp_t e;
    @(negedge clk);
    reset          = r;
    bus.true_fault = tf;
    e.name = name;
    e.val  = ex;
    sb.push_back(e);
    @(posedge clk);
    #1 -> chk_ev;
  endtask

  // tf: '1'/'0' per cycle; ex: 'R' = lamp+relay, 'L' = lamp only, '0' = both off
  task automatic run(input string name, input string tf, input string ex);
    for (int i = 0; i < tf.len(); i++) begin
      byte t, x;
      logic [1:0] v;
      t = tf[i];
      x = ex[i];
      v = (x == "R") ? 2'b11 : (x == "L") ? 2'b10 : 2'b00;
      step(name, 1'b1, (t == "1"), v);
    end
  endtask

  task automatic async_reset(input string name);
    exp_t e;
    #2 reset = 1'b0;
    e.name = name;
    e.val  = 2'b00;
    sb.push_back(e);
    #1 -> chk_ev;
  endtask

  initial begin
    reset          = 1'b0;
    bus.true_fault = 1'b0;

    step("reset_hold", 1'b0, 1'b0, 2'b00);
    step("reset_hold", 1'b0, 1'b0, 2'b00);
    run("lamp_test",   "0000",       "LRRR");
    run("fault_blink", "1111111111", "RR00LL00LL");

`ifdef FSM_LATCH_FAULT_EN
    run("latch_blink", "00000000", "00LL00LL");
    async_reset("async_reset_latch");
    step("reset_hold", 1'b0, 1'b0, 2'b00);
    run("relamp",      "000",          "LRR");
    run("latch_short", "110000000000", "RR00LL00LL00");
`else
    run("recover",     "00000000",       "000000RR");
    run("short_fault", "1100000000",     "RR000000RR");
    run("refault_h3",  "11000110000000", "RR00000000000R");
    run("refault_h4",  "11000010000000", "RR00000000000R");
    run("glitch_hit",  "10000000",       "RR00000R");
    #2 bus.true_fault = 1'b1;
    #2 bus.true_fault = 1'b0;
    run("glitch_miss", "000",   "RRR");
    run("pre_reset",   "11111", "RR00L");
    async_reset("async_reset_fault");
    step("reset_hold", 1'b0, 1'b0, 2'b00);
    run("relamp",      "000",   "LRR");
`endif

    #5;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
